tile_pixel_pipe: RTL and testbench

Pipelined, parametrised successor to the tile-map pixel generator: it maps VGA pixel counters onto a tile grid, classifies each tile as water/block/path, and overlays N round player tokens with fixed priority. Player positions are frame-latched, so mid-frame updates never tear the image. It sits between the VGA sync counter and the DAC pins and adds a fixed 3-cycle latency.

---
 rtl/tile_pixel_pkg.sv | 25 ++
 rtl/tile_pixel_pipe_hit.sv | 56 +++++
 rtl/tile_pixel_pipe.sv | 175 +++++++++++++++++
 tb/tb_tile_pixel_pipe.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pixel_pkg.sv
// Shared colour constants, RGB444 type and tile classification for tile_pixel_pipe.
package tile_pixel_pkg;

  typedef logic [11:0] rgb444_t;

  typedef enum logic [1:0] {
    TILE_WATER,
    TILE_BLOCK,
    TILE_PATH
  } tile_class_e;

  localparam rgb444_t COLOR_WATER = 12'h0f0;
  localparam rgb444_t COLOR_BLOCK = 12'h000;
  localparam rgb444_t COLOR_PATH  = 12'hfff;
  localparam rgb444_t COLOR_OFF   = 12'h000;

  function automatic rgb444_t class_color(input tile_class_e cls);
    case (cls)
      TILE_WATER: class_color = COLOR_WATER;
      TILE_BLOCK: class_color = COLOR_BLOCK;
      default:    class_color = COLOR_PATH;
    endcase
  endfunction

endpackage

// File: rtl/tile_pixel_pipe_hit.sv
// Stages 1-2 of the token test for one player: tile match, centre offsets, then
// squared distance against RADIUS^2. hit_o is combinational from the stage-1 registers.
module tile_hit_test #(
  parameter int TILE_LOG2 = 6,
  parameter int H_TILES   = 10,
  parameter int V_TILES   = 6,
  parameter int RADIUS    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           col_i,
  input  logic [9:0]           row_i,
  input  logic [TILE_LOG2-1:0] off_h_i,
  input  logic [TILE_LOG2-1:0] off_v_i,
  input  logic [3:0]           tile_h_i,
  input  logic [3:0]           tile_v_i,
  input  logic                 enable_i,
  output logic                 hit_o
);

  localparam int SUMW = 2 * TILE_LOG2 + 2;
  localparam logic [TILE_LOG2:0] HALF      = (TILE_LOG2 + 1)'(1 << (TILE_LOG2 - 1));
  localparam logic [SUMW-1:0]    RADIUS_SQ = SUMW'(RADIUS * RADIUS);

  logic                        inTile_d, inTile_q;
  logic signed [TILE_LOG2:0]   dx_d, dy_d, dx_q, dy_q;
  logic signed [SUMW-1:0]      dxWide, dyWide;
  logic        [SUMW-1:0]      distSq;

  // A player parked outside the drawn map can never match a drawn tile.
  always_comb begin
    inTile_d = enable_i
            && (10'(tile_h_i) < 10'(H_TILES)) && (10'(tile_v_i) < 10'(V_TILES))
            && (10'(tile_h_i) == col_i) && (10'(tile_v_i) == row_i);
    dx_d = $signed({1'b0, off_h_i} - HALF);
    dy_d = $signed({1'b0, off_v_i} - HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inTile_q <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else begin
      inTile_q <= inTile_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
    end
  end

  assign dxWide = {{(SUMW - TILE_LOG2 - 1){dx_q[TILE_LOG2]}}, dx_q};
  assign dyWide = {{(SUMW - TILE_LOG2 - 1){dy_q[TILE_LOG2]}}, dy_q};
  assign distSq = dxWide * dxWide + dyWide * dyWide;
  assign hit_o  = inTile_q && (distSq < RADIUS_SQ);

endmodule

// File: rtl/tile_pixel_pipe.sv
// Three-stage tile-map pixel generator with frame-latched player tokens.
// Optional PIXEL_BLINK_EN adds a per-frame blink counter that hides blinking players.
module tile_pixel_pipe #(
  parameter int TILE_LOG2  = 6,
  parameter int H_TILES    = 10,
  parameter int V_TILES    = 6,
  parameter int NPLAYER    = 2,
  parameter int RADIUS     = 16,
  parameter int WATER_MOD  = 3,
  parameter int BLOCK_MOD  = 4,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              h_cnt,
  input  logic [9:0]              v_cnt,
  input  logic                    valid,
  input  logic                    frame_start,
  input  logic [4*NPLAYER-1:0]    player_h,
  input  logic [4*NPLAYER-1:0]    player_v,
  input  logic [12*NPLAYER-1:0]   player_color,
  input  logic [NPLAYER-1:0]      player_blink,
  output logic [3:0]              vgaRed,
  output logic [3:0]              vgaGreen,
  output logic [3:0]              vgaBlue,
  output logic                    pix_valid
);

  import tile_pixel_pkg::*;

  localparam logic [9:0] WMOD = 10'(WATER_MOD);
  localparam logic [9:0] BMOD = 10'(BLOCK_MOD);

  logic [NPLAYER-1:0][3:0]  shadowH_q, shadowV_q;
  logic [NPLAYER-1:0][11:0] shadowColor_q;
  logic [NPLAYER-1:0]       suppress, hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadowH_q     <= '0;
      shadowV_q     <= '0;
      shadowColor_q <= '0;
    end else if (frame_start) begin
      shadowH_q     <= player_h;
      shadowV_q     <= player_v;
      shadowColor_q <= player_color;
    end
  end

`ifdef PIXEL_BLINK_EN
  logic [BLINK_LOG2-1:0] blinkCnt_q;
  logic [NPLAYER-1:0]    shadowBlink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blinkCnt_q    <= '0;
      shadowBlink_q <= '0;
    end else if (frame_start) begin
      blinkCnt_q    <= blinkCnt_q + BLINK_LOG2'(1);
      shadowBlink_q <= player_blink;
    end
  end

  assign suppress = shadowBlink_q & {NPLAYER{blinkCnt_q[BLINK_LOG2-1]}};
`else
  localparam int unusedBlinkLog2 = BLINK_LOG2;
  logic unusedBlink;
  assign unusedBlink = ^player_blink;
  assign suppress    = '0;
`endif

  // Stage 1: tile coordinates and out-of-map flag; colours are captured here so a
  // pixel keeps the shadows it was classified with even if they reload behind it.
  logic [9:0]               col, row, col1_q, row1_q;
  logic                     offMap1_d, offMap1_q, valid1_q;
  logic [NPLAYER-1:0][11:0] color1_q;

  assign col       = h_cnt >> TILE_LOG2;
  assign row       = v_cnt >> TILE_LOG2;
  assign offMap1_d = !valid || (col >= 10'(H_TILES)) || (row >= 10'(V_TILES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col1_q    <= '0;
      row1_q    <= '0;
      offMap1_q <= 1'b0;
      valid1_q  <= 1'b0;
      color1_q  <= '0;
    end else begin
      col1_q    <= col;
      row1_q    <= row;
      offMap1_q <= offMap1_d;
      valid1_q  <= valid;
      color1_q  <= shadowColor_q;
    end
  end

  for (genvar p = 0; p < NPLAYER; p++) begin : g_player
    tile_hit_test #(
      .TILE_LOG2(TILE_LOG2),
      .H_TILES  (H_TILES),
      .V_TILES  (V_TILES),
      .RADIUS   (RADIUS)
    ) u_hit (
      .clk     (clk),
      .rst_n   (rst_n),
      .col_i   (col),
      .row_i   (row),
      .off_h_i (h_cnt[TILE_LOG2-1:0]),
      .off_v_i (v_cnt[TILE_LOG2-1:0]),
      .tile_h_i(shadowH_q[p]),
      .tile_v_i(shadowV_q[p]),
      .enable_i(!suppress[p]),
      .hit_o   (hit[p])
    );
  end

  // Stage 2: tile class and lowest-index hitting player (scan high to low so index 0 wins).
  tile_class_e class2_d, class2_q;
  logic        anyHit2_d, anyHit2_q, offMap2_q, valid2_q;
  rgb444_t     hitColor2_d, hitColor2_q;

  always_comb begin
    anyHit2_d   = 1'b0;
    hitColor2_d = COLOR_OFF;
    for (int p = NPLAYER - 1; p >= 0; p--) begin
      if (hit[p]) begin
        anyHit2_d   = 1'b1;
        hitColor2_d = color1_q[p];
      end
    end
    if ((col1_q % WMOD) == 10'd0)      class2_d = TILE_WATER;
    else if ((row1_q % BMOD) == 10'd0) class2_d = TILE_BLOCK;
    else                               class2_d = TILE_PATH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class2_q    <= TILE_WATER;
      anyHit2_q   <= 1'b0;
      hitColor2_q <= COLOR_OFF;
      offMap2_q   <= 1'b0;
      valid2_q    <= 1'b0;
    end else begin
      class2_q    <= class2_d;
      anyHit2_q   <= anyHit2_d;
      hitColor2_q <= hitColor2_d;
      offMap2_q   <= offMap1_q;
      valid2_q    <= valid1_q;
    end
  end

  rgb444_t rgb_d, rgb_q;
  logic    valid3_q;

  always_comb begin
    rgb_d = class_color(class2_q);
    if (offMap2_q)      rgb_d = COLOR_OFF;
    else if (anyHit2_q) rgb_d = hitColor2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= COLOR_OFF;
      valid3_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      valid3_q <= valid2_q;
    end
  end

  assign {vgaRed, vgaGreen, vgaBlue} = rgb_q;
  assign pix_valid = valid3_q;

endmodule

// File: tb/tb_tile_pixel_pipe.sv
// Scoreboard bench for tile_pixel_pipe: expectations queue at drive time, compared 3 cycles later.
// With PIXEL_BLINK_EN defined the DUT is built with BLINK_LOG2=2 and the blink scenario runs.
module tb_tile_pixel_pipe;

  localparam int NP = 2;
  localparam int BL = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [9:0]        h_cnt, v_cnt;
  logic              valid, frame_start;
  logic [4*NP-1:0]   player_h, player_v;
  logic [12*NP-1:0]  player_color;
  logic [NP-1:0]     player_blink;
  logic [3:0]        vgaRed, vgaGreen, vgaBlue;
  logic              pix_valid;

  always #5 clk = ~clk;

  tile_pixel_pipe #(.NPLAYER(NP), .BLINK_LOG2(BL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .frame_start (frame_start),
    .player_h    (player_h),
    .player_v    (player_v),
    .player_color(player_color),
    .player_blink(player_blink),
    .vgaRed      (vgaRed),
    .vgaGreen    (vgaGreen),
    .vgaBlue     (vgaBlue),
    .pix_valid   (pix_valid)
  );

  typedef struct {
    int          h;
    int          v;
    logic        vld;
    logic        fs;
    logic [11:0] rgb;
    logic        chk;
    string       name;
  } stim_t;

  stim_t stimQ[$];
  stim_t expQ[$];
  int    passCnt  = 0;
  int    totalCnt = 0;

  // Reference shadow state, updated whenever the bench issues frame_start.
  logic [3:0]    mH[NP];
  logic [3:0]    mV[NP];
  logic [11:0]   mC[NP];
  logic          mB[NP];
  logic [BL-1:0] mCnt;

  function automatic logic [11:0] modelRgb(input int h, input int v, input logic vld);
    int col = h / 64;
    int row = v / 64;
    int dx  = (h % 64) - 32;
    int dy  = (v % 64) - 32;
    if (!vld || col >= 10 || row >= 6) return 12'h000;
    for (int i = 0; i < NP; i++) begin
      bit vis = 1'b1;
`ifdef PIXEL_BLINK_EN
      if (mB[i] && mCnt[BL-1]) vis = 1'b0;
`endif
      if (vis && int'(mH[i]) == col && int'(mV[i]) == row && (dx * dx + dy * dy) < 256)
        return mC[i];
    end
    if (col % 3 == 0) return 12'h0f0;
    if (row % 4 == 0) return 12'h000;
    return 12'hfff;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NP; i++) begin
      mH[i] = '0; mV[i] = '0; mC[i] = '0; mB[i] = 1'b0;
    end
    mCnt = '0;
  endtask

  task automatic addStim(input int h, input int v, input logic vld, input logic fs,
                         input logic [11:0] rgb, input logic chk, input string nm);
    stimQ.push_back('{h: h, v: v, vld: vld, fs: fs, rgb: rgb, chk: chk, name: nm});
  endtask

  task automatic applyStimulus(input stim_t s);
    h_cnt       = 10'(s.h);
    v_cnt       = 10'(s.v);
    valid       = s.vld;
    frame_start = s.fs;
    expQ.push_back(s);
    if (s.fs) begin
      for (int i = 0; i < NP; i++) begin
        mH[i] = player_h[4*i +: 4];
        mV[i] = player_v[4*i +: 4];
        mC[i] = player_color[12*i +: 12];
        mB[i] = player_blink[i];
      end
      mCnt = mCnt + BL'(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    h_cnt = '0; v_cnt = '0; valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expQ.delete();
    modelReset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stim_t s, e;
    logic [11:0] got;
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus('{h: 100, v: 100, vld: 1'b1, fs: 1'b0, rgb: 12'hfff, chk: 1'b0, name: "fill"});
    #2 rst_n = 1'b0;
    #1;
    totalCnt++;
    if ({pix_valid, vgaRed, vgaGreen, vgaBlue} !== 13'h0)
      $display("[TB] FAIL rst_async_clear: got %h, expected 0", {pix_valid, vgaRed, vgaGreen, vgaBlue});
    else passCnt++;
    expQ.delete();
    modelReset();
    @(posedge clk);
    #1;
    totalCnt++;
    if ({pix_valid, vgaRed, vgaGreen, vgaBlue} !== 13'h0)
      $display("[TB] FAIL rst_held: got %h, expected 0", {pix_valid, vgaRed, vgaGreen, vgaBlue});
    else passCnt++;
    rst_n = 1'b1;
    addStim(100, 100, 1'b1, 1'b0, 12'hfff, 1'b1, "rst_default_path");
    addStim(32,  32,  1'b1, 1'b0, 12'h000, 1'b1, "rst_shadow_black_token");
    addStim(96,  96,  1'b1, 1'b0, 12'hfff, 1'b1, "rst_tile11_centre");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    for (int i = 0; stimQ.size() > 0; i++) begin
      s = stimQ.pop_front();
      applyStimulus(s);
      if (i == 0) begin
        totalCnt++;
        if (pix_valid !== 1'b0)
          $display("[TB] FAIL rst_flushed: got pix_valid=%b, expected 0", pix_valid);
        else passCnt++;
      end
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        got = {vgaRed, vgaGreen, vgaBlue};
        if (e.chk) begin
          totalCnt++;
          if ({pix_valid, got} !== {e.vld, e.rgb})
            $display("[TB] FAIL %s: got pv=%b rgb=%h, expected pv=%b rgb=%h", e.name, pix_valid, got, e.vld, e.rgb);
          else passCnt++;
        end
      end
    end
  endtask

  task automatic test_map();
    stim_t s, e;
    logic [11:0] got;
    addStim(0,   70,  1'b1, 1'b0, 12'h0f0, 1'b1, "map_water");
    addStim(70,  0,   1'b1, 1'b0, 12'h000, 1'b1, "map_block");
    addStim(640, 10,  1'b1, 1'b0, 12'h000, 1'b1, "map_off_right");
    addStim(100, 100, 1'b0, 1'b0, 12'h000, 1'b1, "map_invalid");
    addStim(200, 200, 1'b1, 1'b0, 12'h0f0, 1'b1, "map_water_col3");
    addStim(260, 260, 1'b1, 1'b0, 12'h000, 1'b1, "map_block_row4");
    addStim(330, 140, 1'b1, 1'b0, 12'hfff, 1'b1, "map_path_5_2");
    addStim(639, 383, 1'b1, 1'b0, 12'h0f0, 1'b1, "map_last_pixel");
    addStim(639, 384, 1'b1, 1'b0, 12'h000, 1'b1, "map_off_bottom");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      applyStimulus(s);
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        got = {vgaRed, vgaGreen, vgaBlue};
        if (e.chk) begin
          totalCnt++;
          if ({pix_valid, got} !== {e.vld, e.rgb})
            $display("[TB] FAIL %s: got pv=%b rgb=%h, expected pv=%b rgb=%h", e.name, pix_valid, got, e.vld, e.rgb);
          else passCnt++;
        end
      end
    end
  endtask

  task automatic test_token_edge();
    stim_t s, e;
    logic [11:0] got;
    player_h = {4'd9, 4'd2};
    player_v = {4'd5, 4'd1};
    player_color = {12'h123, 12'h039};
    addStim(0,   0,   1'b0, 1'b1, 12'h000, 1'b0, "tok_load");
    addStim(160, 96,  1'b1, 1'b0, 12'h039, 1'b1, "tok_centre");
    addStim(176, 96,  1'b1, 1'b0, 12'hfff, 1'b1, "tok_dx16_outside");
    addStim(175, 96,  1'b1, 1'b0, 12'h039, 1'b1, "tok_dx15_inside");
    addStim(144, 96,  1'b1, 1'b0, 12'hfff, 1'b1, "tok_dxm16_outside");
    addStim(145, 96,  1'b1, 1'b0, 12'h039, 1'b1, "tok_dxm15_inside");
    addStim(171, 107, 1'b1, 1'b0, 12'h039, 1'b1, "tok_diag_242");
    addStim(172, 108, 1'b1, 1'b0, 12'hfff, 1'b1, "tok_diag_288");
    addStim(608, 352, 1'b1, 1'b0, 12'h123, 1'b1, "tok_player1");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      applyStimulus(s);
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        got = {vgaRed, vgaGreen, vgaBlue};
        if (e.chk) begin
          totalCnt++;
          if ({pix_valid, got} !== {e.vld, e.rgb})
            $display("[TB] FAIL %s: got pv=%b rgb=%h, expected pv=%b rgb=%h", e.name, pix_valid, got, e.vld, e.rgb);
          else passCnt++;
        end
      end
    end
  endtask

  task automatic test_priority_and_tearing();
    stim_t s, e;
    logic [11:0] got;
    player_h = {4'd4, 4'd4};
    player_v = {4'd2, 4'd2};
    player_color = {12'h123, 12'h039};
    addStim(0,   0,   1'b0, 1'b1, 12'h000, 1'b0, "prio_load");
    addStim(288, 160, 1'b1, 1'b0, 12'h039, 1'b1, "prio_centre");
    addStim(300, 160, 1'b1, 1'b0, 12'h039, 1'b1, "prio_dx12");
    addStim(310, 160, 1'b1, 1'b0, 12'hfff, 1'b1, "prio_dx22_outside");
    for (int i = 0; stimQ.size() > 0; i++) begin
      s = stimQ.pop_front();
      applyStimulus(s);
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        got = {vgaRed, vgaGreen, vgaBlue};
        if (e.chk) begin
          totalCnt++;
          if ({pix_valid, got} !== {e.vld, e.rgb})
            $display("[TB] FAIL %s: got pv=%b rgb=%h, expected pv=%b rgb=%h", e.name, pix_valid, got, e.vld, e.rgb);
          else passCnt++;
        end
      end
    end
    // Move player 0 to (1,2) on the inputs only; the image must not change until frame_start.
    player_h = {4'd4, 4'd1};
    addStim(288, 160, 1'b1, 1'b0, 12'h039, 1'b1, "tear_no_fs");
    addStim(288, 160, 1'b1, 1'b1, 12'h039, 1'b1, "tear_fs_same_pixel_old");
    addStim(288, 160, 1'b1, 1'b0, 12'h123, 1'b1, "tear_next_pixel_new");
    addStim(96,  160, 1'b1, 1'b0, 12'h039, 1'b1, "tear_moved_token");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      applyStimulus(s);
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        got = {vgaRed, vgaGreen, vgaBlue};
        if (e.chk) begin
          totalCnt++;
          if ({pix_valid, got} !== {e.vld, e.rgb})
            $display("[TB] FAIL %s: got pv=%b rgb=%h, expected pv=%b rgb=%h", e.name, pix_valid, got, e.vld, e.rgb);
          else passCnt++;
        end
      end
    end
  endtask

`ifdef PIXEL_BLINK_EN
  task automatic test_blink();
    stim_t s, e;
    logic [11:0] got;
    int cnt;
    resetDut();
    player_h = {4'd9, 4'd2};
    player_v = {4'd5, 4'd1};
    player_color = {12'h123, 12'h039};
    player_blink = 2'b01;
    addStim(0, 0, 1'b0, 1'b1, 12'h000, 1'b0, "blink_load");
    for (int f = 1; f <= 5; f++) begin
      cnt = f % 4;
      addStim(160, 96,  1'b1, 1'b0, (cnt >= 2) ? 12'hfff : 12'h039, 1'b1, $sformatf("blink_p0_frame%0d", f));
      addStim(608, 352, 1'b1, 1'b0, 12'h123, 1'b1, $sformatf("blink_p1_frame%0d", f));
      addStim(0, 0, 1'b0, 1'b1, 12'h000, 1'b0, "blink_next_frame");
    end
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    addStim(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      applyStimulus(s);
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        got = {vgaRed, vgaGreen, vgaBlue};
        if (e.chk) begin
          totalCnt++;
          if ({pix_valid, got} !== {e.vld, e.rgb})
            $display("[TB] FAIL %s: got pv=%b rgb=%h, expected pv=%b rgb=%h", e.name, pix_valid, got, e.vld, e.rgb);
          else passCnt++;
        end
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    stim_t s, e;
    logic [11:0] got;
    int h, v, k;
    logic vld, fs;
    for (int i = 0; i < 402; i++) begin
      if (i < 400) begin
        fs = ($urandom_range(0, 15) == 0);
        if (fs) begin
          for (int p = 0; p < NP; p++) begin
            player_h[4*p +: 4]      = 4'($urandom_range(0, 11));
            player_v[4*p +: 4]      = 4'($urandom_range(0, 7));
            player_color[12*p +: 12] = 12'($urandom_range(0, 4095));
            player_blink[p]         = 1'($urandom_range(0, 1));
          end
        end
        vld = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, NP - 1);
          h = int'(mH[k]) * 64 + 12 + $urandom_range(0, 40);
          v = int'(mV[k]) * 64 + 12 + $urandom_range(0, 40);
        end else begin
          h = $urandom_range(0, 700);
          v = $urandom_range(0, 450);
        end
        s = '{h: h, v: v, vld: vld, fs: fs, rgb: modelRgb(h, v, vld), chk: 1'b1, name: "b2b_random"};
      end else begin
        s = '{h: 0, v: 0, vld: 1'b0, fs: 1'b0, rgb: 12'h000, chk: 1'b0, name: "idle"};
      end
      applyStimulus(s);
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        got = {vgaRed, vgaGreen, vgaBlue};
        if (e.chk) begin
          totalCnt++;
          if ({pix_valid, got} !== {e.vld, e.rgb})
            $display("[TB] FAIL %s h=%0d v=%0d: got pv=%b rgb=%h, expected pv=%b rgb=%h",
                     e.name, e.h, e.v, pix_valid, got, e.vld, e.rgb);
          else passCnt++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    h_cnt = '0; v_cnt = '0; valid = 1'b0; frame_start = 1'b0;
    player_h = '0; player_v = '0; player_color = '0; player_blink = '0;
    modelReset();
    test_reset();
    test_map();
    test_token_edge();
    test_priority_and_tearing();
`ifdef PIXEL_BLINK_EN
    test_blink();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
